dcache_share_arbiter: RTL and testbench
=======================================

# dcache_share_arbiter

Round-robin arbiter that shares the single data cache between core0 and core1 in the one-cache resiliency top. It replaces the fixed-priority request mux. It tags each accepted request with its source core and steers each cache response back to only that core. It also caps outstanding requests per core and isolates a core that is held in reset, so the other core keeps full cache access.

## Interface
- `CORE_TAG_BITS`, default 14: width of each core's request/response tag.
- `MAX_OUTST`, default 4: maximum unanswered requests per core (≥1).
- `clk` in 1: sole clock.
- `reset_n` in 1: asynchronous, active-low reset.
- `iso0`, `iso1` in 1: synchronous core-isolation inputs, driven from `reset_core0`/`reset_core1`.
- `cN_req_val` in 1, `cN_req_rdy` out 1 (N=0,1): per-core request handshake.
- `cN_req_op` in 4, `cN_req_addr` in 32, `cN_req_data` in 128, `cN_req_wmask` in 16, `cN_req_tag` in CORE_TAG_BITS: per-core request payload.
- `cN_resp_val` out 1, `cN_resp_tag` out CORE_TAG_BITS: per-core response valid and tag. Response data is broadcast outside this block.
- `dc_req_val` out 1, `dc_req_rdy` in 1: cache request handshake.
- `dc_req_op`/`addr`/`data`/`wmask` out: muxed payload, same widths as the core request payload.
- `dc_req_tag` out CORE_TAG_BITS+1: `{core_id, core_tag}`.
- `dc_resp_val` in 1, `dc_resp_tag` in CORE_TAG_BITS+1: cache response.
- `arb_err` out 1: sticky protocol-error flag.

## Operation
- **Eligibility.** Core N is eligible when all three hold:
  - `cN_req_val` is high.
  - `isoN` is low.
  - outstanding count `cntN` < MAX_OUTST.
- **Priority pointer.** `last` is 1 bit and records the core most recently granted.
  - If both cores are eligible, the grant goes to `~last`.
  - If one core is eligible, it is granted.
  - If none is eligible, `dc_req_val`=0 and the payload holds the core0 value.
- **Sticky grant.** If the granted core is not accepted (`dc_req_rdy`=0), `hold` is set and the grant stays on that core until fire, its isolation, or its valid dropping.
  - `hold` is cleared on fire.
  - While `hold` is set, `last` does not move.
- **Outputs.**
  - `dc_req_val` = granted eligible valid.
  - `cN_req_rdy` = `dc_req_rdy` & grantN & eligibleN.
- **Fire.** Fire = `dc_req_val` & `dc_req_rdy`. On fire, `last` ← granted core and `cnt` of that core increments.
- **Response contract.** Every accepted request yields exactly one cache response.
- **Response steering.**
  - `id` = `dc_resp_tag` MSB.
  - `c[id]_resp_val` = `dc_resp_val` & ~`iso[id]`. The other core's `resp_val` is 0.
  - `cN_resp_tag` = `dc_resp_tag` low bits.
  - On `dc_resp_val`, `cnt[id]` decrements, including while that core is isolated, so that in-flight responses drain.
- **Simultaneous fire and response** for the same core: `cnt` is unchanged.
- **Error conditions.**
  - A response arriving when `cnt[id]`=0: `arb_err` is set, `cnt` stays 0 (no underflow).
  - `arb_err` clears only on `reset_n`.
- **Isolation.**
  - Asserting `isoN` mid-hold drops the grant the same cycle.
  - The other core becomes eligible that same cycle.
  - `cntN` is preserved and drains as described above.

## Timing
- Request path is fully combinational (zero-cycle arbitration). `last`, `hold`, `cnt0`, `cnt1` and `arb_err` are registered.
- Response steering is combinational, zero latency.
- `reset_n` low asynchronously clears:
  - `last`=1, so core0 wins the first tie.
  - `hold`=0, `cnt0`=`cnt1`=0, `arb_err`=0.
- During reset all outputs are 0: `dc_req_val`, `cN_req_rdy`, `cN_resp_val`, and the perf counters.
- Counter width is `$clog2(MAX_OUTST+1)`. Saturation at MAX_OUTST blocks further grants to that core; there is no wrap.
- A cache response may arrive in the same cycle as the fire of its own request only if the cache permits it. The block handles that as an increment plus decrement.

## Configuration
- `DCARB_PERF_EN` defined: adds three 32-bit outputs, all cleared by `reset_n`, wrapping at 2^32.
  - `perf_grant0`: count of core0 fires.
  - `perf_grant1`: count of core1 fires.
  - `perf_conflict`: cycles where both cores are eligible.
- `DCARB_PERF_EN` undefined: the ports and registers are absent; arbitration behaviour is identical.

## Test plan
- **Alternation.** Both cores hold `req_val`=1, `dc_req_rdy`=1, responses returned immediately.
  - Required: after reset, grants go 0,1,0,1.
  - Required: `dc_req_tag` MSB matches the grant each cycle.
- **Sticky grant.** Core0 granted with `dc_req_rdy`=0 for 3 cycles while core1 requests.
  - Required: grant stays on core0.
  - Required: core0 fires on the cycle rdy=1; core1 fires the next cycle.
- **Credit limit.** MAX_OUTST=4, no responses, core0 only.
  - Required: exactly 4 fires, then `c0_req_rdy`=0.
  - Required: one response with tag `{0,x}` re-enables exactly 1 fire.
- **Steering.** Response tag `{1,14'h0ABC}`.
  - Required: `c1_resp_val`=1 with `c1_resp_tag`=14'h0ABC, and `c0_resp_val`=0.
  - Repeat with `iso1`=1: both `resp_val` are 0 and `cnt1` decrements.
- **Error.** Response to core0 while `cnt0`=0.
  - Required: `arb_err`=1 next cycle, held until `reset_n` low.
  - Required: `cnt0` stays 0.
- **Async reset mid-hold.** Pulse `reset_n` low between clock edges.
  - Required: all outputs 0 immediately.
  - Required: after release, core0 wins a tie.
  - With `DCARB_PERF_EN`: counters read 0.

Source files
------------

// File: rtl/dcache_share_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : dcache_share_arbiter
// Purpose  : Round-robin arbiter sharing one data cache between core0 and
//            core1. It tags requests with their source core, steers responses
//            back to that core, caps outstanding requests per core and
//            isolates a core held in reset.
// Options  : DCARB_PERF_EN adds perf_grant0/perf_grant1/perf_conflict
//            32-bit event counters.
// Revision : 1.0 - initial release
// ============================================================================
module dcache_share_arbiter #(
    parameter int CORE_TAG_BITS = 14,
    parameter int MAX_OUTST     = 4
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     iso0,
    input  logic                     iso1,
    // core0 request / response
    input  logic                     c0_req_val,
    output logic                     c0_req_rdy,
    input  logic [3:0]               c0_req_op,
    input  logic [31:0]              c0_req_addr,
    input  logic [127:0]             c0_req_data,
    input  logic [15:0]              c0_req_wmask,
    input  logic [CORE_TAG_BITS-1:0] c0_req_tag,
    output logic                     c0_resp_val,
    output logic [CORE_TAG_BITS-1:0] c0_resp_tag,
    // core1 request / response
    input  logic                     c1_req_val,
    output logic                     c1_req_rdy,
    input  logic [3:0]               c1_req_op,
    input  logic [31:0]              c1_req_addr,
    input  logic [127:0]             c1_req_data,
    input  logic [15:0]              c1_req_wmask,
    input  logic [CORE_TAG_BITS-1:0] c1_req_tag,
    output logic                     c1_resp_val,
    output logic [CORE_TAG_BITS-1:0] c1_resp_tag,
    // cache side
    output logic                     dc_req_val,
    input  logic                     dc_req_rdy,
    output logic [3:0]               dc_req_op,
    output logic [31:0]              dc_req_addr,
    output logic [127:0]             dc_req_data,
    output logic [15:0]              dc_req_wmask,
    output logic [CORE_TAG_BITS:0]   dc_req_tag,
    input  logic                     dc_resp_val,
    input  logic [CORE_TAG_BITS:0]   dc_resp_tag,
`ifdef DCARB_PERF_EN
    output logic [31:0]              perf_grant0,
    output logic [31:0]              perf_grant1,
    output logic [31:0]              perf_conflict,
`endif
    output logic                     arb_err
);

    localparam int               CNT_W   = $clog2(MAX_OUTST + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_OUTST);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic             last_q, last_d;
    logic             hold_q, hold_d;
    logic             hold_id_q, hold_id_d;
    logic [CNT_W-1:0] cnt0_q, cnt0_d, cnt1_q, cnt1_d;
    logic             arb_err_q, arb_err_d;

    logic elig0, elig1, gnt, fire, resp_id;
    logic inc0, inc1, dec0, dec1;

    // Eligibility, grant selection (sticky hold first, then round robin) and request mux.
    always_comb begin
        elig0 = reset_n & c0_req_val & ~iso0 & (cnt0_q < CNT_MAX);
        elig1 = reset_n & c1_req_val & ~iso1 & (cnt1_q < CNT_MAX);
        gnt   = 1'b0;
        if (hold_q && (hold_id_q ? elig1 : elig0)) begin
            gnt = hold_id_q;
        end else if (elig0 && elig1) begin
            gnt = ~last_q;
        end else if (elig1) begin
            gnt = 1'b1;
        end
        dc_req_val   = elig0 | elig1;
        fire         = dc_req_val & dc_req_rdy;
        c0_req_rdy   = dc_req_rdy & ~gnt & elig0;
        c1_req_rdy   = dc_req_rdy & gnt & elig1;
        dc_req_op    = gnt ? c1_req_op    : c0_req_op;
        dc_req_addr  = gnt ? c1_req_addr  : c0_req_addr;
        dc_req_data  = gnt ? c1_req_data  : c0_req_data;
        dc_req_wmask = gnt ? c1_req_wmask : c0_req_wmask;
        dc_req_tag   = {gnt, (gnt ? c1_req_tag : c0_req_tag)};
    end

    // Response steering: the core-id bit picks the single destination core.
    always_comb begin
        resp_id     = dc_resp_tag[CORE_TAG_BITS];
        c0_resp_val = reset_n & dc_resp_val & ~resp_id & ~iso0;
        c1_resp_val = reset_n & dc_resp_val &  resp_id & ~iso1;
        c0_resp_tag = dc_resp_tag[CORE_TAG_BITS-1:0];
        c1_resp_tag = dc_resp_tag[CORE_TAG_BITS-1:0];
    end

    // Next-state for pointer, hold and per-core outstanding credit counters.
    always_comb begin
        inc0      = fire & ~gnt;
        inc1      = fire &  gnt;
        dec0      = dc_resp_val & ~resp_id;
        dec1      = dc_resp_val &  resp_id;
        last_d    = fire ? gnt : last_q;
        hold_d    = 1'b0;
        hold_id_d = hold_id_q;
        if (dc_req_val && !dc_req_rdy) begin
            hold_d    = 1'b1;
            hold_id_d = gnt;
        end
        cnt0_d    = cnt0_q;
        cnt1_d    = cnt1_q;
        arb_err_d = arb_err_q;
        // An increment and decrement together cancel; a lone decrement at zero is an error.
        if (inc0 && !dec0) begin
            cnt0_d = cnt0_q + CNT_ONE;
        end else if (dec0 && !inc0) begin
            if (cnt0_q == '0) arb_err_d = 1'b1;
            else              cnt0_d    = cnt0_q - CNT_ONE;
        end
        if (inc1 && !dec1) begin
            cnt1_d = cnt1_q + CNT_ONE;
        end else if (dec1 && !inc1) begin
            if (cnt1_q == '0) arb_err_d = 1'b1;
            else              cnt1_d    = cnt1_q - CNT_ONE;
        end
    end

    // State registers; last resets to 1 so core0 wins the first tie.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            last_q    <= 1'b1;
            hold_q    <= 1'b0;
            hold_id_q <= 1'b0;
            cnt0_q    <= '0;
            cnt1_q    <= '0;
            arb_err_q <= 1'b0;
        end else begin
            last_q    <= last_d;
            hold_q    <= hold_d;
            hold_id_q <= hold_id_d;
            cnt0_q    <= cnt0_d;
            cnt1_q    <= cnt1_d;
            arb_err_q <= arb_err_d;
        end
    end

    assign arb_err = arb_err_q;

`ifdef DCARB_PERF_EN
    logic [31:0] perf_grant0_q, perf_grant0_d;
    logic [31:0] perf_grant1_q, perf_grant1_d;
    logic [31:0] perf_conflict_q, perf_conflict_d;

    // Free-running wrap-around event counters.
    always_comb begin
        perf_grant0_d   = perf_grant0_q   + {31'd0, inc0};
        perf_grant1_d   = perf_grant1_q   + {31'd0, inc1};
        perf_conflict_d = perf_conflict_q + {31'd0, (elig0 & elig1)};
    end

    // Perf counter registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            perf_grant0_q   <= '0;
            perf_grant1_q   <= '0;
            perf_conflict_q <= '0;
        end else begin
            perf_grant0_q   <= perf_grant0_d;
            perf_grant1_q   <= perf_grant1_d;
            perf_conflict_q <= perf_conflict_d;
        end
    end

    assign perf_grant0   = perf_grant0_q;
    assign perf_grant1   = perf_grant1_q;
    assign perf_conflict = perf_conflict_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_dcache_share_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_dcache_share_arbiter
// Purpose  : Self-checking bench for dcache_share_arbiter. Expected grant
//            order is queued per scenario and checked on every observed fire.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dcache_share_arbiter;
    localparam int TB = 14;
    localparam logic [TB-1:0] TAG0  = 14'h0011;
    localparam logic [TB-1:0] TAG1  = 14'h2233;
    localparam logic [3:0]    OP0   = 4'h1;
    localparam logic [3:0]    OP1   = 4'h9;
    localparam logic [31:0]   ADDR0 = 32'h1000_0040;
    localparam logic [31:0]   ADDR1 = 32'h2000_0080;
    localparam logic [127:0]  DATA0 = 128'h0123_4567_89ab_cdef_0011_2233_4455_6677;
    localparam logic [127:0]  DATA1 = 128'hfedc_ba98_7654_3210_8899_aabb_ccdd_eeff;
    localparam logic [15:0]   WM0   = 16'h00ff;
    localparam logic [15:0]   WM1   = 16'hf00f;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset_n, iso0, iso1;
    logic c0_req_val, c0_req_rdy, c0_resp_val, c1_req_val, c1_req_rdy, c1_resp_val;
    logic [3:0] c0_req_op, c1_req_op, dc_req_op;
    logic [31:0] c0_req_addr, c1_req_addr, dc_req_addr;
    logic [127:0] c0_req_data, c1_req_data, dc_req_data;
    logic [15:0] c0_req_wmask, c1_req_wmask, dc_req_wmask;
    logic [TB-1:0] c0_req_tag, c1_req_tag, c0_resp_tag, c1_resp_tag;
    logic dc_req_val, dc_req_rdy, dc_resp_val, arb_err;
    logic [TB:0] dc_req_tag, dc_resp_tag;
`ifdef DCARB_PERF_EN
    logic [31:0] perf_grant0, perf_grant1, perf_conflict;
`endif

    dcache_share_arbiter #(.CORE_TAG_BITS(TB), .MAX_OUTST(4)) dut (
        .clk(clk), .reset_n(reset_n), .iso0(iso0), .iso1(iso1),
        .c0_req_val(c0_req_val), .c0_req_rdy(c0_req_rdy), .c0_req_op(c0_req_op),
        .c0_req_addr(c0_req_addr), .c0_req_data(c0_req_data), .c0_req_wmask(c0_req_wmask),
        .c0_req_tag(c0_req_tag), .c0_resp_val(c0_resp_val), .c0_resp_tag(c0_resp_tag),
        .c1_req_val(c1_req_val), .c1_req_rdy(c1_req_rdy), .c1_req_op(c1_req_op),
        .c1_req_addr(c1_req_addr), .c1_req_data(c1_req_data), .c1_req_wmask(c1_req_wmask),
        .c1_req_tag(c1_req_tag), .c1_resp_val(c1_resp_val), .c1_resp_tag(c1_resp_tag),
        .dc_req_val(dc_req_val), .dc_req_rdy(dc_req_rdy), .dc_req_op(dc_req_op),
        .dc_req_addr(dc_req_addr), .dc_req_data(dc_req_data), .dc_req_wmask(dc_req_wmask),
        .dc_req_tag(dc_req_tag), .dc_resp_val(dc_resp_val), .dc_resp_tag(dc_resp_tag),
`ifdef DCARB_PERF_EN
        .perf_grant0(perf_grant0), .perf_grant1(perf_grant1), .perf_conflict(perf_conflict),
`endif
        .arb_err(arb_err)
    );

    int n_cmp = 0;
    int n_bad = 0;
    logic exp_q[$];          // expected granted core, one entry per fire
    logic fired;
    logic [TB:0] fired_tag;

    // One cycle: drive inputs after the falling edge, then score any fire.
    task automatic step(input logic v0, input logic v1, input logic rdy, input logic rv,
                        input logic [TB:0] rtag, input logic i0, input logic i1);
        logic id;
        logic [TB:0] et;
        logic [179:0] ep, gp;
        @(negedge clk);
        c0_req_val = v0; c1_req_val = v1; dc_req_rdy = rdy;
        dc_resp_val = rv; dc_resp_tag = rtag; iso0 = i0; iso1 = i1;
        #1;
        fired     = dc_req_val & dc_req_rdy;
        fired_tag = dc_req_tag;
        if (fired) begin
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_bad++;
                $display("FAIL sb_unexpected_fire: got tag %h, required no fire", dc_req_tag);
            end else begin
                id = exp_q.pop_front();
                et = {id, (id ? TAG1 : TAG0)};
                ep = id ? {OP1, ADDR1, DATA1, WM1} : {OP0, ADDR0, DATA0, WM0};
                gp = {dc_req_op, dc_req_addr, dc_req_data, dc_req_wmask};
                if (dc_req_tag !== et || gp !== ep) begin
                    n_bad++;
                    $display("FAIL sb_fire: got tag %h payload %h, required tag %h payload %h",
                             dc_req_tag, gp, et, ep);
                end
            end
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset_n = 1'b0; c0_req_val = 0; c1_req_val = 0; dc_req_rdy = 0;
        dc_resp_val = 0; dc_resp_tag = '0; iso0 = 0; iso1 = 0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        exp_q.delete();
    endtask

    task automatic test_reset();
        @(negedge clk);
        reset_n = 0; c0_req_val = 1; c1_req_val = 1; dc_req_rdy = 1;
        dc_resp_val = 1; dc_resp_tag = {1'b1, 14'h0001};
        #1;
        n_cmp++; if (dc_req_val !== 1'b0) begin n_bad++; $display("FAIL rst_dc_req_val: got %b required 0", dc_req_val); end
        n_cmp++; if (c0_req_rdy !== 1'b0) begin n_bad++; $display("FAIL rst_c0_req_rdy: got %b required 0", c0_req_rdy); end
        n_cmp++; if (c1_req_rdy !== 1'b0) begin n_bad++; $display("FAIL rst_c1_req_rdy: got %b required 0", c1_req_rdy); end
        n_cmp++; if (c1_resp_val !== 1'b0) begin n_bad++; $display("FAIL rst_c1_resp_val: got %b required 0", c1_resp_val); end
        n_cmp++; if (arb_err !== 1'b0) begin n_bad++; $display("FAIL rst_arb_err: got %b required 0", arb_err); end
        @(negedge clk);
        c0_req_val = 0; c1_req_val = 0; dc_req_rdy = 0; dc_resp_val = 0; reset_n = 1;
    endtask

    task automatic test_alternation();
        logic pf;
        logic [TB:0] pt;
        do_reset();
        exp_q.push_back(0); exp_q.push_back(1); exp_q.push_back(0); exp_q.push_back(1);
        pf = 0; pt = '0;
        for (int i = 0; i < 4; i++) begin
            step(1, 1, 1, pf, pt, 0, 0);
            n_cmp++; if (fired !== 1'b1) begin n_bad++; $display("FAIL alt_fire[%0d]: got %b required 1", i, fired); end
            pf = fired; pt = fired_tag;
        end
        step(0, 0, 1, pf, pt, 0, 0);
        n_cmp++; if (exp_q.size() != 0) begin n_bad++; $display("FAIL alt_sb_empty: got %0d left required 0", exp_q.size()); end
        @(negedge clk);
        n_cmp++; if (arb_err !== 1'b0) begin n_bad++; $display("FAIL alt_arb_err: got %b required 0", arb_err); end
`ifdef DCARB_PERF_EN
        n_cmp++; if (perf_grant0 !== 32'd2) begin n_bad++; $display("FAIL alt_perf_grant0: got %0d required 2", perf_grant0); end
        n_cmp++; if (perf_grant1 !== 32'd2) begin n_bad++; $display("FAIL alt_perf_grant1: got %0d required 2", perf_grant1); end
        n_cmp++; if (perf_conflict !== 32'd4) begin n_bad++; $display("FAIL alt_perf_conflict: got %0d required 4", perf_conflict); end
`endif
    endtask

    task automatic test_sticky();
        do_reset();
        exp_q.push_back(0); exp_q.push_back(0); exp_q.push_back(1);
        step(1, 0, 1, 0, '0, 0, 0);                    // core0 fires, last -> 0
        step(1, 0, 0, 1, {1'b0, TAG0}, 0, 0);          // core0 granted, stalled
        n_cmp++; if (dc_req_tag[TB] !== 1'b0) begin n_bad++; $display("FAIL sticky_first: got %b required 0", dc_req_tag[TB]); end
        for (int i = 0; i < 2; i++) begin
            step(1, 1, 0, 0, '0, 0, 0);
            n_cmp++; if (dc_req_tag[TB] !== 1'b0 || dc_req_val !== 1'b1) begin
                n_bad++; $display("FAIL sticky_hold[%0d]: got val %b id %b required val 1 id 0", i, dc_req_val, dc_req_tag[TB]);
            end
        end
        step(1, 1, 1, 0, '0, 0, 0);
        n_cmp++; if (c0_req_rdy !== 1'b1) begin n_bad++; $display("FAIL sticky_c0_rdy: got %b required 1", c0_req_rdy); end
        step(1, 1, 1, 0, '0, 0, 0);
        n_cmp++; if (c1_req_rdy !== 1'b1) begin n_bad++; $display("FAIL sticky_c1_rdy: got %b required 1", c1_req_rdy); end
        step(0, 0, 0, 0, '0, 0, 0);
        n_cmp++; if (exp_q.size() != 0) begin n_bad++; $display("FAIL sticky_sb_empty: got %0d left required 0", exp_q.size()); end
    endtask

    task automatic test_isolation();
        do_reset();
        exp_q.push_back(1);
        step(1, 1, 0, 0, '0, 0, 0);
        n_cmp++; if (dc_req_tag[TB] !== 1'b0) begin n_bad++; $display("FAIL iso_pre: got %b required 0", dc_req_tag[TB]); end
        step(1, 1, 0, 0, '0, 1, 0);
        n_cmp++; if (dc_req_tag[TB] !== 1'b1 || dc_req_val !== 1'b1) begin
            n_bad++; $display("FAIL iso_switch: got val %b id %b required val 1 id 1", dc_req_val, dc_req_tag[TB]);
        end
        step(1, 1, 1, 0, '0, 1, 0);
        n_cmp++; if (c0_req_rdy !== 1'b0) begin n_bad++; $display("FAIL iso_c0_rdy: got %b required 0", c0_req_rdy); end
        step(0, 0, 0, 0, '0, 0, 0);
        n_cmp++; if (exp_q.size() != 0) begin n_bad++; $display("FAIL iso_sb_empty: got %0d left required 0", exp_q.size()); end
    endtask

    task automatic test_credit();
        int nf;
        do_reset();
        repeat (4) exp_q.push_back(0);
        nf = 0;
        for (int i = 0; i < 6; i++) begin
            step(1, 0, 1, 0, '0, 0, 0);
            if (fired) nf++;
        end
        n_cmp++; if (nf != 4) begin n_bad++; $display("FAIL credit_fires: got %0d required 4", nf); end
        n_cmp++; if (c0_req_rdy !== 1'b0) begin n_bad++; $display("FAIL credit_block: got %b required 0", c0_req_rdy); end
        exp_q.push_back(0);
        step(1, 0, 1, 1, {1'b0, 14'h0123}, 0, 0);
        n_cmp++; if (c0_req_rdy !== 1'b0) begin n_bad++; $display("FAIL credit_resp_cycle_rdy: got %b required 0", c0_req_rdy); end
        n_cmp++; if (c0_resp_val !== 1'b1 || c0_resp_tag !== 14'h0123) begin
            n_bad++; $display("FAIL credit_resp: got val %b tag %h required val 1 tag 0123", c0_resp_val, c0_resp_tag);
        end
        step(1, 0, 1, 0, '0, 0, 0);
        n_cmp++; if (fired !== 1'b1) begin n_bad++; $display("FAIL credit_refire: got %b required 1", fired); end
        step(1, 0, 1, 0, '0, 0, 0);
        n_cmp++; if (c0_req_rdy !== 1'b0) begin n_bad++; $display("FAIL credit_reblock: got %b required 0", c0_req_rdy); end
        step(0, 0, 0, 0, '0, 0, 0);
        n_cmp++; if (exp_q.size() != 0) begin n_bad++; $display("FAIL credit_sb_empty: got %0d left required 0", exp_q.size()); end
    endtask

    task automatic test_steering();
        int nf;
        do_reset();
        repeat (4) exp_q.push_back(1);
        repeat (4) step(0, 1, 1, 0, '0, 0, 0);
        step(0, 0, 0, 1, {1'b1, 14'h0ABC}, 0, 0);
        n_cmp++; if (c1_resp_val !== 1'b1 || c1_resp_tag !== 14'h0ABC) begin
            n_bad++; $display("FAIL steer_c1: got val %b tag %h required val 1 tag 0abc", c1_resp_val, c1_resp_tag);
        end
        n_cmp++; if (c0_resp_val !== 1'b0) begin n_bad++; $display("FAIL steer_c0_quiet: got %b required 0", c0_resp_val); end
        step(0, 0, 0, 1, {1'b1, 14'h0ABC}, 0, 1);
        n_cmp++; if (c1_resp_val !== 1'b0 || c0_resp_val !== 1'b0) begin
            n_bad++; $display("FAIL steer_iso: got c0 %b c1 %b required 0 0", c0_resp_val, c1_resp_val);
        end
        // Two credits returned (one while isolated): exactly two more fires.
        exp_q.push_back(1); exp_q.push_back(1);
        nf = 0;
        for (int i = 0; i < 3; i++) begin
            step(0, 1, 1, 0, '0, 0, 0);
            if (fired) nf++;
        end
        n_cmp++; if (nf != 2) begin n_bad++; $display("FAIL steer_drain_fires: got %0d required 2", nf); end
        n_cmp++; if (arb_err !== 1'b0) begin n_bad++; $display("FAIL steer_arb_err: got %b required 0", arb_err); end
        step(0, 0, 0, 0, '0, 0, 0);
        n_cmp++; if (exp_q.size() != 0) begin n_bad++; $display("FAIL steer_sb_empty: got %0d left required 0", exp_q.size()); end
    endtask

    task automatic test_error();
        int nf;
        do_reset();
        step(0, 0, 0, 1, {1'b0, 14'h0055}, 0, 0);
        n_cmp++; if (arb_err !== 1'b0) begin n_bad++; $display("FAIL err_early: got %b required 0", arb_err); end
        step(0, 0, 0, 0, '0, 0, 0);
        n_cmp++; if (arb_err !== 1'b1) begin n_bad++; $display("FAIL err_set: got %b required 1", arb_err); end
        // A counter left at zero still admits exactly four requests.
        repeat (4) exp_q.push_back(0);
        nf = 0;
        for (int i = 0; i < 5; i++) begin
            step(1, 0, 1, 0, '0, 0, 0);
            if (fired) nf++;
        end
        n_cmp++; if (nf != 4) begin n_bad++; $display("FAIL err_no_underflow: got %0d fires required 4", nf); end
        n_cmp++; if (arb_err !== 1'b1) begin n_bad++; $display("FAIL err_sticky: got %b required 1", arb_err); end
        do_reset();
        #1;
        n_cmp++; if (arb_err !== 1'b0) begin n_bad++; $display("FAIL err_cleared: got %b required 0", arb_err); end
    endtask

    task automatic test_async_reset();
        do_reset();
        exp_q.push_back(0);
        step(1, 0, 1, 0, '0, 0, 0);                    // last -> 0
        step(1, 1, 0, 0, '0, 0, 0);                    // tie goes to core1, held
        n_cmp++; if (dc_req_tag[TB] !== 1'b1) begin n_bad++; $display("FAIL ar_pre_grant: got %b required 1", dc_req_tag[TB]); end
        #1;
        dc_req_rdy = 1; dc_resp_val = 1; dc_resp_tag = {1'b1, 14'h0002}; reset_n = 0;
        #1;
        n_cmp++; if (dc_req_val !== 1'b0 || c0_req_rdy !== 1'b0 || c1_req_rdy !== 1'b0) begin
            n_bad++; $display("FAIL ar_req_zero: got val %b rdy0 %b rdy1 %b required 0 0 0", dc_req_val, c0_req_rdy, c1_req_rdy);
        end
        n_cmp++; if (c1_resp_val !== 1'b0) begin n_bad++; $display("FAIL ar_resp_zero: got %b required 0", c1_resp_val); end
`ifdef DCARB_PERF_EN
        n_cmp++; if (perf_grant0 !== 32'd0 || perf_grant1 !== 32'd0 || perf_conflict !== 32'd0) begin
            n_bad++; $display("FAIL ar_perf_zero: got %0d %0d %0d required 0 0 0", perf_grant0, perf_grant1, perf_conflict);
        end
`endif
        dc_resp_val = 0; reset_n = 1;
        #1;
        n_cmp++; if (dc_req_val !== 1'b1 || dc_req_tag[TB] !== 1'b0 || c0_req_rdy !== 1'b1) begin
            n_bad++; $display("FAIL ar_tie_core0: got val %b id %b rdy0 %b required 1 0 1", dc_req_val, dc_req_tag[TB], c0_req_rdy);
        end
        step(0, 0, 0, 0, '0, 0, 0);
        n_cmp++; if (exp_q.size() != 0) begin n_bad++; $display("FAIL ar_sb_empty: got %0d left required 0", exp_q.size()); end
    endtask

    initial begin
        reset_n = 0; iso0 = 0; iso1 = 0; c0_req_val = 0; c1_req_val = 0;
        dc_req_rdy = 0; dc_resp_val = 0; dc_resp_tag = '0;
        c0_req_op = OP0; c0_req_addr = ADDR0; c0_req_data = DATA0; c0_req_wmask = WM0; c0_req_tag = TAG0;
        c1_req_op = OP1; c1_req_addr = ADDR1; c1_req_data = DATA1; c1_req_wmask = WM1; c1_req_tag = TAG1;
        test_reset();
        test_alternation();
        test_sticky();
        test_isolation();
        test_credit();
        test_steering();
        test_error();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
`default_nettype wire
